// File: rtl/pressure_frame_controller_pkg.sv
// Shared widths, FSM state type and helpers for the pressure frame receiver.
package pressure_frame_controller_pkg;

    localparam int unsigned FRAME_W  = 6;
    localparam int unsigned DATA_W   = 5;
    localparam int unsigned ERRCNT_W = 8;
    localparam int unsigned RETRY_W  = 4;
    localparam int unsigned TIMER_W  = 8;
    localparam int unsigned BITCNT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CHECK,
        S_RESEND,
        S_HOLD,
        S_FAULT
    } state_t;

    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
        return (v == '1) ? v : v + ERRCNT_W'(1);
    endfunction

endpackage

// File: rtl/pressure_frame_controller_if.sv
// Sensor serial link plus output valid/ready handshake of the frame controller.
interface pressure_frame_controller_if;
    import pressure_frame_controller_pkg::*;

    logic              ser_bit;
    logic              ser_valid;
    logic              resend_req;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output ser_bit, ser_valid, out_ready,
        input  resend_req, out_data, out_valid
    );

    modport slave (
        input  ser_bit, ser_valid, out_ready,
        output resend_req, out_data, out_valid
    );

endinterface

// File: rtl/pressure_frame_controller_parity.sv
// 6-bit odd-parity checker: not_error is high when the frame holds an odd number of ones.
module pressure_frame_controller_parity
    import pressure_frame_controller_pkg::*;
(
    input  logic [FRAME_W-1:0] word,
    output logic               not_error
);

    assign not_error = ^word;

endmodule

// File: rtl/pressure_frame_controller.sv
// Receives serial pressure frames, checks parity, retries on error/timeout and
// hands good values to the consumer over valid/ready.
module pressure_frame_controller
    import pressure_frame_controller_pkg::*;
#(
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    pressure_frame_controller_if.slave bus,
    output logic                  busy,
    output logic                  fault,
    output logic [ERRCNT_W-1:0]   err_count
);

    state_t                state_q, state_d;
    logic [FRAME_W-1:0]    shift_q, shift_d;
    logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [RETRY_W-1:0]    retry_q, retry_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [ERRCNT_W-1:0]   errcnt_q, errcnt_d;
    logic [DATA_W-1:0]     out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  not_error;
    logic                  take_err;

    pressure_frame_controller_parity u_parity (
        .word      (shift_q),
        .not_error (not_error)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            retry_q     <= '0;
            timer_q     <= '0;
            errcnt_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            retry_q     <= retry_d;
            timer_q     <= timer_d;
            errcnt_q    <= errcnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bitcnt_d    = bitcnt_q;
        retry_d     = retry_q;
        timer_d     = timer_q;
        errcnt_d    = errcnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        take_err    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SHIFT;
                    retry_d  = '0;
                    bitcnt_d = '0;
                    timer_d  = '0;
                end
            end
            S_SHIFT: begin
                if (bus.ser_valid) begin
                    shift_d = {shift_q[FRAME_W-2:0], bus.ser_bit};
                    timer_d = '0;
                    if (bitcnt_q == BITCNT_W'(FRAME_W - 1)) begin
                        bitcnt_d = '0;
                        state_d  = S_CHECK;
                    end else begin
                        bitcnt_d = bitcnt_q + BITCNT_W'(1);
                    end
                end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                    take_err = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            S_CHECK: begin
                if (not_error) begin
                    state_d     = S_HOLD;
                    out_data_d  = shift_q[FRAME_W-1:1];
                    out_valid_d = 1'b1;
                end else begin
                    take_err = 1'b1;
                end
            end
            S_RESEND: begin
                bitcnt_d = '0;
                timer_d  = '0;
                state_d  = S_SHIFT;
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (start) begin
                        state_d  = S_SHIFT;
                        retry_d  = '0;
                        bitcnt_d = '0;
                        timer_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_FAULT: begin
                if (start) begin
                    state_d  = S_SHIFT;
                    retry_d  = '0;
                    bitcnt_d = '0;
                    timer_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Timeout and parity failure share one path so retries count both alike.
        if (take_err) begin
            errcnt_d = sat_inc(errcnt_q);
            if (retry_q == RETRY_W'(MAX_RETRY)) begin
                state_d = S_FAULT;
            end else begin
                retry_d = retry_q + RETRY_W'(1);
                state_d = S_RESEND;
            end
        end
    end

    assign bus.resend_req = (state_q == S_RESEND);
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign busy           = (state_q == S_SHIFT) || (state_q == S_CHECK) ||
                            (state_q == S_RESEND) || (state_q == S_HOLD);
    assign fault          = (state_q == S_FAULT);
    assign err_count      = errcnt_q;

endmodule
